// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: op encoding, default width, stage payload.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // Payload carried by every stage register, shown at the default width.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0]         data;
    logic [$clog2(DEFAULT_WIDTH)-1:0] shamt;
    op_e                              op;
    logic                             sign;
    logic                             valid;
  } payload_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: fixed 2^K shift/fill mux, payload register, ready logic.
// Rotate wrap is only built when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int K     = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [$clog2(WIDTH)-1:0]   shamt_i,
  input  op_e                        op_i,
  input  logic                       sign_i,
  input  logic                       ready_next_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(WIDTH)-1:0]   shamt_o,
  output op_e                        op_o,
  output logic                       sign_o
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int SH      = 1 << K;

  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_d;
  logic [SHAMT_W-1:0] shamt_q;
  op_e                op_q;
  logic               sign_q;

  // SRA fills from the sign captured at accept, not from the partially shifted value.
  always_comb begin
    data_d = data_i;
    if (shamt_i[K]) begin
      case (op_i)
        OP_SRL: data_d = data_i >> SH;
        OP_SRA: data_d = {{SH{sign_i}}, data_i[WIDTH-1:SH]};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        OP_ROL: data_d = {data_i[WIDTH-SH-1:0], data_i[WIDTH-1:WIDTH-SH]};
`endif
        default: data_d = data_i << SH;
      endcase
    end
  end

  assign ready_o = !valid_q || ready_next_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
      sign_q  <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      op_q    <= op_i;
      sign_q  <= sign_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Fully pipelined barrel shifter, one stage per shift-amount bit, valid/ready on both sides.
// Define PIPELINED_SHIFTER_ROTATE_EN to make op 11 rotate-left; otherwise it shifts left.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [SHAMT_W-1:0]           in_shamt,
  input  logic [1:0]                   in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(SHAMT_W+1)-1:0] inflight
);

  localparam int LAT   = SHAMT_W;
  localparam int CNT_W = $clog2(LAT + 1);

  // Index k feeds stage k; stage k's registered payload appears at index k+1.
  logic               valid_s [LAT+1];
  logic [WIDTH-1:0]   data_s  [LAT+1];
  logic [SHAMT_W-1:0] shamt_s [LAT+1];
  op_e                op_s    [LAT+1];
  logic               sign_s  [LAT+1];
  logic               ready_s [LAT+1];

  logic               accept;
  logic               emit;
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   inflight_d;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign shamt_s[0] = in_shamt;
  assign op_s[0]    = op_e'(in_op);
  assign sign_s[0]  = in_data[WIDTH-1];
  assign ready_s[LAT] = out_ready;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clock        (clock),
      .reset        (reset),
      .valid_i      (valid_s[k]),
      .data_i       (data_s[k]),
      .shamt_i      (shamt_s[k]),
      .op_i         (op_s[k]),
      .sign_i       (sign_s[k]),
      .ready_next_i (ready_s[k+1]),
      .ready_o      (ready_s[k]),
      .valid_o      (valid_s[k+1]),
      .data_o       (data_s[k+1]),
      .shamt_o      (shamt_s[k+1]),
      .op_o         (op_s[k+1]),
      .sign_o       (sign_s[k+1])
    );
  end

  assign in_ready  = ready_s[0] && !reset;
  assign out_valid = valid_s[LAT];
  assign out_data  = data_s[LAT];

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !emit) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (emit && !accept) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at WIDTH 32: directed vectors, backpressure, reset flush, throughput.
module tb_pipelined_shifter;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_shamt = 5'd0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  inflight;

  pipelined_shifter #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .inflight  (inflight)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    int          sh;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   saw_full = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: compares every output handshake against the scoreboard head.
  initial begin
    exp_t        e;
    bit          stalled_prev;
    logic [31:0] held;
    stalled_prev = 1'b0;
    held = 32'd0;
    forever begin
      @(negedge clock);
      if (!mon_en || reset) begin
        stalled_prev = 1'b0;
      end else begin
        chk("inflight", 32'(inflight), 32'(sb.size()));
        if (inflight == 3'd5 && !out_ready) begin
          saw_full = 1'b1;
          chk("in_ready_when_full", 32'(in_ready), 32'd0);
        end
        if (stalled_prev) chk("out_data_hold", out_data, held);
        stalled_prev = out_valid && !out_ready;
        held = out_data;
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("stale_out_valid", 32'(out_valid), 32'd0);
          end else if (out_ready) begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            if (e.lat) chk("latency", 32'(cyc - e.c), 32'(LAT));
          end
        end
      end
    end
  end

  // Offer one op; called just after a rising edge, returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input int sh, input logic [1:0] op,
                      input logic [31:0] exp, input bit lat, output int stalls);
    int   n;
    int   c0;
    exp_t t;
    n = 0;
    in_valid = 1'b1;
    in_data  = a;
    in_shamt = sh[4:0];
    in_op    = op;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        c0 = cyc;
        @(posedge clock);
        #1;
        t.d = exp;
        t.c = c0;
        t.lat = lat;
        sb.push_back(t);
        break;
      end
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        break;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_data  = ~a;
    in_shamt = ~sh[4:0];
    stalls = n;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];
  int   st;
  int   st_total;

  initial begin
    logic [31:0] rol_a;
    logic [31:0] rol_b;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    rol_a = 32'h0000_0018;
    rol_b = 32'h5678_1234;
`else
    rol_a = 32'h0000_0010;
    rol_b = 32'h5678_0000;
`endif
    vecs.push_back('{32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 31, 2'b01, 32'h0000_0001});
    vecs.push_back('{32'h7FFF_FFFF,  4, 2'b10, 32'h07FF_FFFF});
    vecs.push_back('{32'h8000_0001,  4, 2'b11, rol_a});
    vecs.push_back('{32'hDEAD_BEEF,  0, 2'b00, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF,  0, 2'b01, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF,  0, 2'b10, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF,  0, 2'b11, 32'hDEAD_BEEF});
    vecs.push_back('{32'hF000_0000,  3, 2'b10, 32'hFE00_0000});
    vecs.push_back('{32'hF000_0000,  3, 2'b01, 32'h1E00_0000});
    vecs.push_back('{32'h0000_0001, 31, 2'b00, 32'h8000_0000});
    vecs.push_back('{32'h1234_5678, 16, 2'b11, rol_b});
    vecs.push_back('{32'h8000_0000,  1, 2'b10, 32'hC000_0000});

    // Reset state
    idle(3);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    mon_en = 1'b1;
    @(posedge clock);
    #1;

    // Lone SLL with latency check, then directed vectors back-to-back
    send(32'h0000_00FF, 8, 2'b00, 32'h0000_FF00, 1'b1, st);
    idle(8);
    st_total = 0;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].sh, vecs[i].op, vecs[i].exp, 1'b1, st);
      st_total += st;
    end
    chk("vector_stalls", 32'(st_total), 32'd0);
    idle(10);

    // Backpressure: out_ready low for cycles 3..9 while 8 SLL ops stream in
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i), 1, 2'b00, 32'(2 * i), 1'b0, st);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(7);
        out_ready = 1'b1;
        @(negedge clock);
        chk("full_at_release", 32'(inflight), 32'd5);
        chk("accept_on_release", 32'(in_ready), 32'd1);
      end
    join
    chk("saw_full", 32'(saw_full), 32'd1);
    idle(12);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) send(32'h0000_0F00 + 32'(i), 4, 2'b01, 32'h0000_00F0, 1'b0, st);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_inflight", 32'(inflight), 32'd0);
    @(posedge clock);
    #1;
    idle(10);

    // Full-pipe throughput: 25 back-to-back ops, out_ready held high
    st_total = 0;
    for (int i = 0; i < 25; i++) begin
      send(32'(i) << 8, 8, 2'b01, 32'(i), 1'b1, st);
      st_total += st;
    end
    chk("throughput_stalls", 32'(st_total), 32'd0);

    // Drain
    for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
